// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand-fetch path.
//  DATA_W   : register/operand width
//  NREGS    : architectural register count
//  ADDR_W   : register address width
//  OP_W     : ALU opcode width
//  ALU_*    : ALU opcode encodings (passed through untouched by this stage)
//  REG_ZERO : hard-wired zero register index
package alu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned NREGS  = 32;
   localparam int unsigned ADDR_W = $clog2(NREGS);
   localparam int unsigned OP_W   = 4;

   localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [OP_W-1:0] ALU_SLL  = 4'b0001;
   localparam logic [OP_W-1:0] ALU_SLT  = 4'b0010;
   localparam logic [OP_W-1:0] ALU_SLTU = 4'b0011;
   localparam logic [OP_W-1:0] ALU_XOR  = 4'b0100;
   localparam logic [OP_W-1:0] ALU_SRL  = 4'b0101;
   localparam logic [OP_W-1:0] ALU_OR   = 4'b0110;
   localparam logic [OP_W-1:0] ALU_AND  = 4'b0111;
   localparam logic [OP_W-1:0] ALU_SUB  = 4'b1010;
   localparam logic [OP_W-1:0] ALU_SRA  = 4'b1101;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   // True when a register index names a real, writable register.
   function automatic logic is_live_reg(input logic [ADDR_W-1:0] r);
      return r != REG_ZERO;
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: NREGS x DATA_W, two combinational read ports, one write port.
// Register 0 always reads zero and ignores writes.
// Optional macro REGFILE_BYPASS_EN: a same-cycle write to the register being
// read is forwarded to the read port (write-then-read). Without it the old
// value is returned and the new one is visible from the next cycle.
//  clk, reset : clock (rising edge), asynchronous active-high reset
//  ra1, ra2   : read addresses
//  rd1, rd2   : read data
//  we, wa, wd : write enable, address, data
module regfile_2r1w
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] mem [NREGS];
   logic              wr_live;

   assign wr_live = we && is_live_reg(wa);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem <= '{default: '0};
      end else if (wr_live) begin
         mem[wa] <= wd;
      end
   end

   always_comb begin
      rd1 = '0;
      if (is_live_reg(ra1)) begin
`ifdef REGFILE_BYPASS_EN
         rd1 = (wr_live && (wa == ra1)) ? wd : mem[ra1];
`else
         rd1 = mem[ra1];
`endif
      end
   end

   always_comb begin
      rd2 = '0;
      if (is_live_reg(ra2)) begin
`ifdef REGFILE_BYPASS_EN
         rd2 = (wr_live && (wa == ra2)) ? wd : mem[ra2];
`else
         rd2 = mem[ra2];
`endif
      end
   end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage feeding the ALU: reads rs1/rs2 from the register file,
// selects b from rs2 or the (already sign-extended) immediate, and holds the
// operation in a single output slot with valid/ready handshakes on both sides.
// Operands are snapshotted at load and not refreshed while the slot stalls.
// Build option REGFILE_BYPASS_EN enables write-then-read forwarding in the
// register file.
//  clk, reset          : clock, asynchronous active-high reset
//  in_valid, in_ready  : upstream handshake (decode slot)
//  rs1, rs2, rd        : source/destination registers
//  imm, use_imm        : immediate and b-source select
//  aluop_in            : ALU opcode, passed through
//  flush               : drop the held slot, suppress this cycle's load
//  wb_en, wb_addr, wb_data : register writeback port
//  out_valid, out_ready: downstream handshake (ALU)
//  a, b, aluop, out_rd : registered operation to the ALU
module alu_operand_stage
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] imm,
   input  logic              use_imm,
   input  logic [OP_W-1:0]   aluop_in,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [OP_W-1:0]   aluop,
   output logic [ADDR_W-1:0] out_rd
);

   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic [DATA_W-1:0] b_next;
   logic              load;

   regfile_2r1w u_regfile (
      .clk   (clk),
      .reset (reset),
      .ra1   (rs1),
      .ra2   (rs2),
      .rd1   (rd1),
      .rd2   (rd2),
      .we    (wb_en),
      .wa    (wb_addr),
      .wd    (wb_data)
   );

   // Slot is free when empty or being drained this cycle: no bubble while streaming.
   assign in_ready = !out_valid || out_ready;

   // Flush wins over a load even though in_ready may still advertise acceptance.
   assign load = in_valid && in_ready && !flush;

   assign b_next = use_imm ? imm : rd2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         a         <= '0;
         b         <= '0;
         aluop     <= '0;
         out_rd    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         a         <= rd1;
         b         <= b_next;
         aluop     <= aluop_in;
         out_rd    <= rd;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic        use_imm;
   logic [3:0]  aluop_in;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] a, b;
   logic [3:0]  aluop;
   logic [4:0]  out_rd;

   int n_checks = 0;
   int n_fail   = 0;

   alu_operand_stage dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rs1       (rs1),
      .rs2       (rs2),
      .rd        (rd),
      .imm       (imm),
      .use_imm   (use_imm),
      .aluop_in  (aluop_in),
      .flush     (flush),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a         (a),
      .b         (b),
      .aluop     (aluop),
      .out_rd    (out_rd)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [4:0]  rd;
   } op_t;

   logic [31:0] mreg [32];
   op_t         exp_q[$];   // operations held by the stage (at most one)
   logic        exp_rdy;
   logic        obs_rdy;

   function automatic logic [31:0] mread(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      if (wb_en && wb_addr == r) return wb_data;
`endif
      return mreg[r];
   endfunction

   function automatic op_t cur_out();
      return '{a: a, b: b, op: aluop, rd: out_rd};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      exp_q.delete();
   endtask

   task automatic idle_inputs();
      in_valid = 0; rs1 = 0; rs2 = 0; rd = 0; imm = 0; use_imm = 0;
      aluop_in = 0; flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
   endtask

   // One clock: inputs already driven; model advanced to match the edge.
   task automatic tick();
      op_t nxt;
      logic fire, consume;
      #1;
      exp_rdy = (exp_q.size() == 0) || out_ready;
      obs_rdy = in_ready;
      fire    = in_valid && exp_rdy && !flush;
      consume = (exp_q.size() != 0) && out_ready;
      nxt.a   = mread(rs1);
      nxt.b   = use_imm ? imm : mread(rs2);
      nxt.op  = aluop_in;
      nxt.rd  = rd;
      @(posedge clk);
      #1;
      if (flush) exp_q.delete();
      else begin
         if (consume) void'(exp_q.pop_front());
         if (fire) exp_q.push_back(nxt);
      end
      if (wb_en && wb_addr != 0) mreg[wb_addr] = wb_data;
   endtask

   task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
      idle_inputs();
      wb_en = 1; wb_addr = r; wb_data = v;
      tick();
      wb_en = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      out_ready = 1;
      reset = 1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || a !== 32'd0 || b !== 32'd0 || aluop !== 4'd0 || out_rd !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_init: valid=%b a=%h b=%h op=%h rd=%h, required all zero", out_valid, a, b, aluop, out_rd);
      end
      reset = 0;
      write_reg(5'd5, 32'hCAFE_F00D);
      write_reg(5'd3, 32'h1234_5678);
      // Load an op and stall it.
      out_ready = 0;
      in_valid = 1; rs1 = 3; rs2 = 5; rd = 9; aluop_in = 4'b1010;
      tick();
      in_valid = 0;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || a !== 32'h1234_5678 || b !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL reset_prestall: valid=%b a=%h b=%h, required 1 12345678 cafef00d", out_valid, a, b);
      end
      // Asynchronous reset between edges.
      #2 reset = 1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || a !== 32'd0 || b !== 32'd0 || aluop !== 4'd0 || out_rd !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_async: valid=%b a=%h b=%h op=%h rd=%h, required all zero", out_valid, a, b, aluop, out_rd);
      end
      model_clear();
      @(posedge clk);
      #1 reset = 0;
      out_ready = 1;
      in_valid = 1; rs1 = 5; rs2 = 3; rd = 1; aluop_in = 0;
      tick();
      in_valid = 0;
      n_checks++;
      if (out_valid !== 1'b1 || a !== 32'd0 || b !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_regs: valid=%b a=%h b=%h, required 1 0 0", out_valid, a, b);
      end
      tick();
   endtask

   task automatic test_basic();
      write_reg(5'd3, 32'h2000);
      write_reg(5'd4, 32'h17FB);
      out_ready = 1;
      in_valid = 1; rs1 = 3; rs2 = 4; use_imm = 0; aluop_in = 4'b0000; rd = 5'd12;
      tick();
      in_valid = 0;
      n_checks++;
      if (out_valid !== 1'b1 || a !== 32'h2000 || b !== 32'h17FB || aluop !== 4'b0000 || out_rd !== 5'd12) begin
         n_fail++;
         $display("FAIL basic_op: valid=%b a=%h b=%h op=%b rd=%0d, required 1 2000 17fb 0000 12", out_valid, a, b, aluop, out_rd);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_drain: valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_zero_reg_imm();
      write_reg(5'd0, 32'hDEAD);
      out_ready = 1;
      in_valid = 1; rs1 = 0; rs2 = 0; use_imm = 1; imm = 32'h2; aluop_in = 4'b0010; rd = 5'd7;
      tick();
      in_valid = 0; use_imm = 0;
      n_checks++;
      if (a !== 32'd0 || b !== 32'h2 || aluop !== 4'b0010) begin
         n_fail++;
         $display("FAIL zero_reg_imm: a=%h b=%h op=%b, required 0 2 0010", a, b, aluop);
      end
      // Negative immediate passes through without change.
      in_valid = 1; use_imm = 1; imm = 32'hFFFF_FFF0; rs1 = 3;
      tick();
      in_valid = 0; use_imm = 0;
      n_checks++;
      if (a !== 32'h2000 || b !== 32'hFFFF_FFF0) begin
         n_fail++;
         $display("FAIL imm_neg: a=%h b=%h, required 2000 fffffff0", a, b);
      end
      tick();
   endtask

   task automatic test_same_cycle_wb();
      logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
      want = 32'h55;
`else
      want = 32'h0;
`endif
      idle_inputs();
      out_ready = 1;
      wb_en = 1; wb_addr = 7; wb_data = 32'h55;
      in_valid = 1; rs1 = 7; rs2 = 7;
      tick();
      idle_inputs();
      n_checks++;
      if (a !== want || b !== want) begin
         n_fail++;
         $display("FAIL same_cycle_wb: a=%h b=%h, required %h", a, b, want);
      end
      in_valid = 1; rs1 = 7;
      tick();
      in_valid = 0;
      n_checks++;
      if (a !== 32'h55) begin
         n_fail++;
         $display("FAIL wb_next_cycle: a=%h, required 55", a);
      end
      tick();
   endtask

   task automatic test_stall_back_to_back();
      idle_inputs();
      out_ready = 1;
      in_valid = 1; rs1 = 3; use_imm = 1; imm = 32'd100; aluop_in = 4'd1;
      tick();
      // Stall with a new op waiting; R[3] changes during the stall.
      out_ready = 0; imm = 32'd101;
      wb_en = 1; wb_addr = 3; wb_data = 32'hABCD;
      for (int i = 0; i < 3; i++) begin
         tick();
         wb_en = 0;
         n_checks++;
         if (obs_rdy !== 1'b0 || out_valid !== 1'b1 || a !== 32'h2000 || b !== 32'd100) begin
            n_fail++;
            $display("FAIL stall_%0d: in_ready=%b valid=%b a=%h b=%0d, required 0 1 2000 100", i, obs_rdy, out_valid, a, b);
         end
      end
      out_ready = 1;
      for (int j = 0; j < 4; j++) begin
         imm = 32'd101 + j;
         tick();
         n_checks++;
         if (obs_rdy !== 1'b1 || out_valid !== 1'b1 || b !== 32'd101 + j || a !== 32'hABCD) begin
            n_fail++;
            $display("FAIL b2b_%0d: in_ready=%b valid=%b a=%h b=%0d, required 1 1 abcd %0d", j, obs_rdy, out_valid, a, b, 101 + j);
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_flush();
      logic [31:0] held_a, held_b;
      idle_inputs();
      out_ready = 1;
      in_valid = 1; rs1 = 3; use_imm = 1; imm = 32'h77;
      tick();
      held_a = a; held_b = b;
      imm = 32'h88; flush = 1;
      wb_en = 1; wb_addr = 9; wb_data = 32'h9999;
      tick();
      flush = 0; in_valid = 0; wb_en = 0;
      n_checks++;
      if (obs_rdy !== 1'b1 || out_valid !== 1'b0 || a !== held_a || b !== held_b) begin
         n_fail++;
         $display("FAIL flush: in_ready=%b valid=%b a=%h b=%h, required 1 0 %h %h", obs_rdy, out_valid, a, b, held_a, held_b);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_dropped: valid=%b, required 0", out_valid);
      end
      in_valid = 1; rs1 = 9; use_imm = 0;
      tick();
      in_valid = 0;
      n_checks++;
      if (a !== 32'h9999) begin
         n_fail++;
         $display("FAIL flush_wb: a=%h, required 9999", a);
      end
      tick();
   endtask

   task automatic test_random();
      op_t obs;
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         rs1       = 5'($urandom_range(0, 7));
         rs2       = 5'($urandom_range(0, 7));
         rd        = 5'($urandom);
         imm       = $urandom;
         use_imm   = $urandom_range(0, 1) != 0;
         aluop_in  = 4'($urandom);
         wb_en     = $urandom_range(0, 1) != 0;
         wb_addr   = 5'($urandom_range(0, 7));
         wb_data   = $urandom;
         tick();
         n_checks++;
         obs = cur_out();
         if (obs_rdy !== exp_rdy || out_valid !== (exp_q.size() != 0) ||
             (exp_q.size() != 0 && obs !== exp_q[0])) begin
            n_fail++;
            $display("FAIL random_%0d: in_ready=%b valid=%b out=%h, required %b %b %h", i, obs_rdy, out_valid, obs,
                     exp_rdy, exp_q.size() != 0, (exp_q.size() != 0) ? exp_q[0] : obs);
         end
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      idle_inputs();
      out_ready = 1;
      reset = 1;
      test_reset();
      test_basic();
      test_zero_reg_imm();
      test_same_cycle_wb();
      test_stall_back_to_back();
      test_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
